// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the mano_seq_ctrl sequencer: state enum,
// ALU function codes, common-bus select codes and instruction field positions.
package ctrl_pkg;

    typedef enum logic [4:0] {
        FETCH0, FETCH1, DECODE, INDIR, EXEC_RD, EXEC_ALU, EXEC_WR, BUN,
        BSA_WR, BSA_JMP, ISZ_INC, ISZ_WR, EXEC_REG, EXEC_IO, HALT,
        INT0, INT1, INT2
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_LDA = 4'b0010;
    localparam logic [3:0] ALU_CMA = 4'b0011;
    localparam logic [3:0] ALU_CIR = 4'b0100;
    localparam logic [3:0] ALU_CIL = 4'b0101;
    localparam logic [3:0] ALU_CLA = 4'b0110;
    localparam logic [3:0] ALU_INC = 4'b0111;
    localparam logic [3:0] ALU_CLE = 4'b1000;
    localparam logic [3:0] ALU_CME = 4'b1001;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // Field positions counted down from the top of the instruction word
    localparam int I_OFS      = 1;
    localparam int OPC_HI_OFS = 2;
    localparam int OPC_LO_OFS = 4;
    localparam int RR_W       = 12;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_RR  = 3'd7;

    localparam int RR_CLA = 11, RR_CLE = 10, RR_CMA = 9, RR_CME = 8;
    localparam int RR_CIR = 7, RR_CIL = 6, RR_INC = 5, RR_SPA = 4;
    localparam int RR_SNA = 3, RR_SZA = 2, RR_SZE = 1, RR_HLT = 0;
    localparam int IO_ION = 7, IO_IOF = 6;

endpackage

// File: rtl/ctrl_rr_dec.sv
// Combinational register-reference decoder: ALU function, AC/E load enables,
// skip condition and halt request from the low 12 instruction bits.
module ctrl_rr_dec
    import ctrl_pkg::*;
(
    input  logic [RR_W-1:0] rr_bits,
    input  logic            ac_zero,
    input  logic            ac_msb,
    input  logic            e_val,
    output logic [3:0]      alu_op,
    output logic            ac_ld,
    output logic            e_en,
    output logic            skip,
    output logic            hlt
);

    // AC-modifying ops take precedence over E-only ops when several bits are set
    always_comb begin
        if      (rr_bits[RR_CLA]) alu_op = ALU_CLA;
        else if (rr_bits[RR_CMA]) alu_op = ALU_CMA;
        else if (rr_bits[RR_CIR]) alu_op = ALU_CIR;
        else if (rr_bits[RR_CIL]) alu_op = ALU_CIL;
        else if (rr_bits[RR_INC]) alu_op = ALU_INC;
        else if (rr_bits[RR_CLE]) alu_op = ALU_CLE;
        else if (rr_bits[RR_CME]) alu_op = ALU_CME;
        else                      alu_op = ALU_NOP;
    end

    assign ac_ld = rr_bits[RR_CLA] | rr_bits[RR_CMA] | rr_bits[RR_CIR] |
                   rr_bits[RR_CIL] | rr_bits[RR_INC];
    assign e_en  = rr_bits[RR_CLE] | rr_bits[RR_CME] | rr_bits[RR_CIR] |
                   rr_bits[RR_CIL];
    assign skip  = (rr_bits[RR_SPA] & ~ac_msb) | (rr_bits[RR_SNA] & ac_msb) |
                   (rr_bits[RR_SZA] & ac_zero) | (rr_bits[RR_SZE] & ~e_val);
    assign hlt   = rr_bits[RR_HLT];

endmodule

// File: rtl/mano_seq_ctrl.sv
// Self-sequencing control FSM for the accumulator CPU with ready-handshake
// memory access. Define CTRL_INTR_EN to build in the interrupt cycle.
module mano_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] ir_odat,
    input  logic          mem_rdy,
    input  logic          ac_zero,
    input  logic          ac_msb,
    input  logic          e_val,
    input  logic          dr_zero,
    input  logic          run,
    input  logic          intr_req,
    output logic [2:0]    bus_sel,
    output logic          ar_ld,
    output logic          ar_inc,
    output logic          ar_clr,
    output logic          pc_ld,
    output logic          pc_inc,
    output logic          pc_clr,
    output logic          dr_ld,
    output logic          dr_inc,
    output logic          ac_ld,
    output logic          ir_ld,
    output logic          e_en,
    output logic          mem_re,
    output logic          mem_we,
    output logic [3:0]    alu_op,
    output logic          halted,
    output logic          ien
);

    state_t     state, exec_st, done_st;
    logic       ien_q;
    logic       i_bit;
    logic [2:0] opc;
    logic [3:0] rr_alu;
    logic       rr_ac_ld, rr_e_en, rr_skip, rr_hlt;
    logic          unused_ir;
    logic [AW-1:0] unused_addr;

    assign i_bit       = ir_odat[DW-I_OFS];
    assign opc         = ir_odat[DW-OPC_HI_OFS:DW-OPC_LO_OFS];
    assign unused_ir   = ^{ir_odat, intr_req};
    assign unused_addr = ir_odat[AW-1:0];

    ctrl_rr_dec u_rr_dec (
        .rr_bits (ir_odat[RR_W-1:0]),
        .ac_zero (ac_zero),
        .ac_msb  (ac_msb),
        .e_val   (e_val),
        .alu_op  (rr_alu),
        .ac_ld   (rr_ac_ld),
        .e_en    (rr_e_en),
        .skip    (rr_skip),
        .hlt     (rr_hlt)
    );

    always_comb begin
        case (opc)
            OP_STA:  exec_st = EXEC_WR;
            OP_BUN:  exec_st = BUN;
            OP_BSA:  exec_st = BSA_WR;
            default: exec_st = EXEC_RD;
        endcase
    end

    // Interrupts are sampled only at instruction boundaries, using ien as it
    // stood during the instruction just finished.
    always_comb begin
        done_st = FETCH0;
`ifdef CTRL_INTR_EN
        if (ien_q && intr_req) done_st = INT0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH0;
            ien_q <= 1'b0;
        end else begin
            case (state)
                FETCH0:   state <= FETCH1;
                FETCH1:   if (mem_rdy) state <= DECODE;
                DECODE: begin
                    if (opc == OP_RR) state <= i_bit ? EXEC_IO : EXEC_REG;
                    else if (i_bit)   state <= INDIR;
                    else              state <= exec_st;
                end
                INDIR:    if (mem_rdy) state <= exec_st;
                EXEC_RD:  if (mem_rdy) state <= (opc == OP_ISZ) ? ISZ_INC : EXEC_ALU;
                EXEC_ALU: state <= done_st;
                EXEC_WR:  if (mem_rdy) state <= done_st;
                BUN:      state <= done_st;
                BSA_WR:   if (mem_rdy) state <= BSA_JMP;
                BSA_JMP:  state <= done_st;
                ISZ_INC:  state <= ISZ_WR;
                ISZ_WR:   if (mem_rdy) state <= done_st;
                EXEC_REG: state <= rr_hlt ? HALT : done_st;
                EXEC_IO: begin
                    state <= done_st;
`ifdef CTRL_INTR_EN
                    if (ir_odat[IO_IOF])      ien_q <= 1'b0;
                    else if (ir_odat[IO_ION]) ien_q <= 1'b1;
`endif
                end
                HALT:     if (run) state <= done_st;
`ifdef CTRL_INTR_EN
                INT0:     state <= INT1;
                INT1:     if (mem_rdy) state <= INT2;
                INT2: begin
                    state <= FETCH0;
                    ien_q <= 1'b0;
                end
`endif
                default:  state <= FETCH0;
            endcase
        end
    end

    // Outputs decode from state and the live handshake so that a reset or an
    // unready memory suppresses strobes in the very same cycle.
    always_comb begin
        bus_sel = BUS_NONE;
        {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr} = '0;
        {dr_ld, dr_inc, ac_ld, ir_ld, e_en, mem_re, mem_we} = '0;
        alu_op = ALU_AND;
        if (rst_n) begin
            case (state)
                FETCH0:   begin bus_sel = BUS_PC; ar_ld = 1'b1; end
                FETCH1:   begin bus_sel = BUS_MEM; mem_re = 1'b1; ir_ld = mem_rdy; pc_inc = mem_rdy; end
                DECODE:   begin bus_sel = BUS_IR; ar_ld = 1'b1; end
                INDIR:    begin bus_sel = BUS_MEM; mem_re = 1'b1; ar_ld = mem_rdy; end
                EXEC_RD:  begin bus_sel = BUS_MEM; mem_re = 1'b1; dr_ld = mem_rdy; end
                EXEC_ALU: begin
                    ac_ld  = 1'b1;
                    e_en   = (opc == OP_ADD);
                    alu_op = (opc == OP_AND) ? ALU_AND : (opc == OP_ADD) ? ALU_ADD : ALU_LDA;
                end
                EXEC_WR:  begin bus_sel = BUS_AC; mem_we = 1'b1; end
                BUN,
                BSA_JMP:  begin bus_sel = BUS_AR; pc_ld = 1'b1; end
                BSA_WR:   begin bus_sel = BUS_PC; mem_we = 1'b1; ar_inc = mem_rdy; end
                ISZ_INC:  dr_inc = 1'b1;
                ISZ_WR:   begin bus_sel = BUS_DR; mem_we = 1'b1; pc_inc = mem_rdy & dr_zero; end
                EXEC_REG: begin alu_op = rr_alu; ac_ld = rr_ac_ld; e_en = rr_e_en; pc_inc = rr_skip; end
`ifdef CTRL_INTR_EN
                INT0:     ar_clr = 1'b1;
                INT1:     begin bus_sel = BUS_PC; mem_we = 1'b1; pc_clr = mem_rdy; end
                INT2:     pc_inc = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign halted = rst_n & (state == HALT);
    assign ien    = rst_n & ien_q;

endmodule
